// File: rtl/query_loader.sv
`default_nettype none
// ============================================================================
// Module   : query_loader
// Purpose  : Upstream feeder for the vocabulary matcher. Loads a byte-stream
//            query into the matcher input memory from a programmable base,
//            appends the zero terminator, starts the matcher, and forwards
//            its found/done result downstream with an error flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   base_addr       first memory address of the query (taken on first byte)
//   in_valid/in_ready/in_data/in_last
//                   query byte stream (transfer on in_valid && in_ready)
//   wr_en/wr_addr/wr_data
//                   input-memory write port
//   match_rst       re-arm pulse to the matcher (high during/just after reset)
//   match_cs        one-cycle matcher start
//   match_done/match_found
//                   matcher completion and hit flag
//   result_valid/result_ready/result_found/result_err
//                   result handshake towards the consumer
// ============================================================================
module query_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  match_rst,
  output logic                  match_cs,
  input  logic                  match_done,
  input  logic                  match_found,
  output logic                  result_valid,
  output logic                  result_found,
  output logic                  result_err,
  input  logic                  result_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_TERM   = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  // Last memory slot; a character here would leave no room for the terminator.
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic                  any_q, any_d;      // at least one character written
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  match_rst_q, match_rst_d;
  logic                  match_cs_q, match_cs_d;
  logic                  result_valid_q, result_valid_d;
  logic                  result_found_q, result_found_d;
  logic                  result_err_q, result_err_d;

  logic                  hs;
  logic [ADDR_WIDTH-1:0] ptr_cur;
  logic                  err_cur;
  logic                  any_cur;

  assign hs = in_valid && in_ready_q;

  // The first byte is handled in IDLE with the same rules as LOAD, using the
  // freshly sampled base and cleared flags instead of the stored ones.
  assign ptr_cur = (state_q == S_IDLE) ? base_addr : ptr_q;
  assign err_cur = (state_q == S_IDLE) ? 1'b0 : err_q;
  assign any_cur = (state_q == S_IDLE) ? 1'b0 : any_q;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    err_d          = err_q;
    any_d          = any_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    match_rst_d    = 1'b0;
    result_found_d = result_found_q;
    result_err_d   = result_err_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (hs) begin
          ptr_d = ptr_cur;
          err_d = err_cur;
          any_d = any_cur;
          if (in_data == '0) begin
            err_d   = err_cur | ~any_cur;
            state_d = in_last ? S_TERM : S_DRAIN;
          end else if (ptr_cur == PTR_MAX) begin
            err_d   = 1'b1;
            state_d = in_last ? S_TERM : S_DRAIN;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_cur;
            wr_data_d = in_data;
            ptr_d     = ptr_cur + 1'b1;
            any_d     = 1'b1;
            state_d   = in_last ? S_TERM : S_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (hs && in_last) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (!err_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = '0;
          state_d   = S_START;
        end else begin
          result_found_d = 1'b0;
          result_err_d   = 1'b1;
          state_d        = S_RESULT;
        end
      end
      S_START: begin
        // match_done is ignored here; the matcher needs at least two cycles.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (match_done) begin
          result_found_d = match_found;
          result_err_d   = err_q;
          state_d        = S_RESULT;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          match_rst_d    = 1'b1;
          result_found_d = 1'b0;
          result_err_d   = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // State-derived outputs are registered from the next state so they line
    // up with the state they describe.
    in_ready_d     = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DRAIN);
    match_cs_d     = (state_d == S_START);
    result_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      err_q          <= 1'b0;
      any_q          <= 1'b0;
      in_ready_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      match_rst_q    <= 1'b1;
      match_cs_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_found_q <= 1'b0;
      result_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      err_q          <= err_d;
      any_q          <= any_d;
      in_ready_q     <= in_ready_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      match_rst_q    <= match_rst_d;
      match_cs_q     <= match_cs_d;
      result_valid_q <= result_valid_d;
      result_found_q <= result_found_d;
      result_err_q   <= result_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign match_rst    = match_rst_q;
  assign match_cs     = match_cs_q;
  assign result_valid = result_valid_q;
  assign result_found = result_found_q;
  assign result_err   = result_err_q;

endmodule
`default_nettype wire

// File: tb/tb_query_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_query_loader
// Purpose  : Directed self-checking bench for query_loader with a small
//            matcher model and a write logger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_query_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] base_addr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       match_rst;
  logic       match_cs;
  logic       match_done  = 1'b0;
  logic       match_found = 1'b0;
  logic       result_valid;
  logic       result_found;
  logic       result_err;
  logic       result_ready;

  query_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .match_rst    (match_rst),
    .match_cs     (match_cs),
    .match_done   (match_done),
    .match_found  (match_found),
    .result_valid (result_valid),
    .result_found (result_found),
    .result_err   (result_err),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          cs_cnt, mr_cnt, last_cyc, cs_cyc;
  logic [31:0] wlog[$];
  int          mdelay = 5;
  logic        mfound = 1'b1;
  int          mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records writes, starts, re-arm pulses and last-byte timing.
  always @(negedge clk) begin
    if (wr_en) wlog.push_back({20'd0, wr_addr, wr_data});
    if (match_cs) begin
      cs_cnt = cs_cnt + 1;
      cs_cyc = cyc;
    end
    if (match_rst && !rst) mr_cnt = mr_cnt + 1;
    if (in_valid && in_ready && in_last) last_cyc = cyc;
  end

  // Matcher model: done/found appear mdelay cycles after the start pulse and
  // hold until re-armed.
  always @(negedge clk) begin
    if (rst || match_rst) begin
      match_done  = 1'b0;
      match_found = 1'b0;
      mcnt        = 0;
    end else if (match_cs) begin
      mcnt = mdelay;
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        match_done  = 1'b1;
        match_found = mfound;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] we(input int a, input int d);
    return (a << 8) | d;
  endfunction

  function automatic logic [31:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clr();
    wlog.delete();
    cs_cnt   = 0;
    mr_cnt   = 0;
    last_cyc = -100;
    cs_cyc   = -1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_result();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (result_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_mrst_pulse"}, mr_cnt, 1);
    chk({tag, "_valid_drop"}, {31'd0, result_valid}, 0);
  endtask

  initial begin
    rst = 1'b1; base_addr = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; result_ready = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'd0, in_ready, wr_en, match_cs, result_valid, result_found, result_err}, 0);
    chk("rst_mrst", {31'd0, match_rst}, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel1_mrst", {31'd0, match_rst}, 1);
    @(negedge clk);
    chk("rel2_mrst", {31'd0, match_rst}, 0);
    chk("rel2_ready", {31'd0, in_ready}, 1);

    // Normal hit
    gap(1); clr(); mdelay = 5; mfound = 1'b1; base_addr = 4'd2;
    send(8'h61, 1'b0);
    send(8'h62, 1'b1);
    wait_result();
    chk("hit_nwr", wlog.size(), 3);
    chk("hit_w0", wl(0), we(2, 8'h61));
    chk("hit_w1", wl(1), we(3, 8'h62));
    chk("hit_w2", wl(2), we(4, 0));
    chk("hit_cs", cs_cnt, 1);
    chk("hit_lat", cs_cyc - last_cyc, 2);
    chk("hit_res", {30'd0, result_found, result_err}, 2'b10);
    consume("hit");

    // Gaps and result backpressure
    gap(1); clr(); mdelay = 3; mfound = 1'b0; base_addr = 4'd5;
    send(8'h78, 1'b0);
    gap(2);
    send(8'h79, 1'b0);
    send(8'h7a, 1'b1);
    wait_result();
    chk("gap_nwr", wlog.size(), 4);
    chk("gap_w0", wl(0), we(5, 8'h78));
    chk("gap_w1", wl(1), we(6, 8'h79));
    chk("gap_w2", wl(2), we(7, 8'h7a));
    chk("gap_w3", wl(3), we(8, 0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("gap_hold", {29'd0, result_valid, result_found, result_err}, 3'b100);
    end
    chk("gap_nomrst", mr_cnt, 0);
    consume("gap");

    // Overflow
    gap(1); clr(); mdelay = 5; mfound = 1'b1; base_addr = 4'd13;
    send(8'h70, 1'b0);
    send(8'h71, 1'b0);
    send(8'h72, 1'b1);
    wait_result();
    chk("ovf_nwr", wlog.size(), 2);
    chk("ovf_w0", wl(0), we(13, 8'h70));
    chk("ovf_w1", wl(1), we(14, 8'h71));
    chk("ovf_cs", cs_cnt, 0);
    chk("ovf_res", {30'd0, result_found, result_err}, 2'b01);
    consume("ovf");

    // Early zero terminator, remainder drained
    gap(1); clr(); mdelay = 4; mfound = 1'b1; base_addr = 4'd0;
    send(8'h6b, 1'b0);
    send(8'h00, 1'b0);
    send(8'h6d, 1'b1);
    wait_result();
    chk("ez_nwr", wlog.size(), 2);
    chk("ez_w0", wl(0), we(0, 8'h6b));
    chk("ez_w1", wl(1), we(1, 0));
    chk("ez_cs", cs_cnt, 1);
    chk("ez_res", {30'd0, result_found, result_err}, 2'b10);
    consume("ez");

    // Empty query
    gap(1); clr(); base_addr = 4'd7;
    send(8'h00, 1'b1);
    wait_result();
    chk("emp_nwr", wlog.size(), 0);
    chk("emp_cs", cs_cnt, 0);
    chk("emp_res", {30'd0, result_found, result_err}, 2'b01);
    consume("emp");

    // Reset while waiting on the matcher
    gap(1); clr(); mdelay = 40; mfound = 1'b1; base_addr = 4'd3;
    send(8'h51, 1'b1);
    for (int k = 0; k < 20 && cs_cnt == 0; k++) @(negedge clk);
    chk("rw_cs", cs_cnt, 1);
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("rw_outs", {26'd0, in_ready, wr_en, match_cs, result_valid, result_found, result_err}, 0);
    chk("rw_wr", {20'd0, wr_addr, wr_data}, 0);
    chk("rw_mrst", {31'd0, match_rst}, 1);
    chk("rw_state", {29'd0, dut.state_q}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); @(negedge clk);
    gap(1); clr(); mdelay = 5; mfound = 1'b1; base_addr = 4'd10;
    send(8'h75, 1'b0);
    send(8'h76, 1'b1);
    wait_result();
    chk("rw2_nwr", wlog.size(), 3);
    chk("rw2_w0", wl(0), we(10, 8'h75));
    chk("rw2_w1", wl(1), we(11, 8'h76));
    chk("rw2_w2", wl(2), we(12, 0));
    chk("rw2_res", {30'd0, result_found, result_err}, 2'b10);
    consume("rw2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/query_loader.md
Name: query_loader

Overview:
- Upstream feeder for the vocabulary matcher.
- Accepts a query word as a byte stream over a valid/ready handshake and writes it into the input memory starting at a programmable base address. Appends the zero terminator the matcher expects.
- Starts the matcher, waits for its done/found result, presents the result downstream with an error flag, then re-arms the matcher for the next query.

Parameters:
- ADDR_WIDTH, 4, input-memory address width; the memory holds 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, character width; the value 0 is reserved as terminator.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- base_addr  in  ADDR_WIDTH  first input-memory address of the query; sampled on the first accepted byte
- in_valid  in  1  byte valid
- in_data  in  DATA_WIDTH  query character
- in_last  in  1  marks the final byte of the query
- in_ready  out  1  loader can accept a byte
- wr_en  out  1  input-memory write strobe
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- match_rst  out  1  active-high re-arm pulse to the matcher
- match_cs  out  1  matcher start
- match_done  in  1  matcher finished
- match_found  in  1  matcher hit; qualified by match_done
- result_valid  out  1  result available
- result_found  out  1  query is in the vocabulary
- result_err  out  1  overflow or empty query
- result_ready  in  1  downstream consumes the result

Behaviour:
- Reset values: state IDLE; all outputs 0, except match_rst=1 while rst is high and for the first cycle after release.
- All outputs are registered. A byte accepted in cycle N is written in cycle N+1.
- Handshake rule: a byte transfers when in_valid && in_ready.
- Capacity: the query may hold at most cap = 2^ADDR_WIDTH - base - 1 characters, leaving one slot for the terminator. The pointer never wraps.
- IDLE: in_ready=1.
  - On handshake: latch ptr=base_addr and clear the err flag.
  - Handle the byte with the common LOAD rules below, then go to LOAD (or the exit state those rules select).
- LOAD: in_ready=1. On each handshake:
  - in_data==0: treat as end of word. No character write. Go to TERM if in_last, else DRAIN. An empty query (zero characters written) sets err.
  - Else if ptr == 2^ADDR_WIDTH-1 (no room for the terminator): drop the byte, set err, go to TERM if in_last, else DRAIN.
  - Else: write in_data at ptr, ptr+1. If in_last, go to TERM.
- DRAIN: in_ready=1. Discard bytes until an in_last handshake, then go to TERM.
- TERM: in_ready=0.
  - If err is clear, write 0 at ptr and go to START.
  - If err is set, go directly to RESULT with result_found=0.
- START: match_cs=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until match_done=1, then latch result_found=match_found and go to RESULT.
  - No timeout; the matcher always terminates on the vocab end address.
- RESULT: result_valid=1, holding result_found and result_err stable until result_ready=1. On the consume cycle, pulse match_rst for one cycle and go to IDLE.
  - result_valid and result_ready high in the same cycle completes the transfer in that cycle.
- Simultaneous events:
  - match_done during START is ignored; the matcher cannot finish in under two cycles.
  - in_valid outside IDLE/LOAD/DRAIN is not accepted (in_ready=0).
- Reset mid-operation: immediate return to IDLE and match_rst asserts. A partially written query is abandoned; memory contents are not cleaned.
- Throughput: one byte per cycle sustained in LOAD. Latency from last byte accepted to match_cs is 2 cycles.

Test Plan:
- Normal hit: base=2; send 'a','b'(last) back-to-back; model returns done=1, found=1 after 5 cycles.
  - Required: writes 2:'a', 3:'b', 4:0.
  - Required: match_cs pulses once, 2 cycles after the last byte.
  - Required: result_valid=1, found=1, err=0; match_rst pulses on consume.
- Backpressure and gaps: in_valid toggles 1,0,0,1,1(last) with 'x','y','z'.
  - Required: exactly three character writes at consecutive addresses, then the terminator.
  - Required: result_ready held low 4 cycles keeps the result stable.
- Overflow: ADDR_WIDTH=4, base=13; send 'p','q','r'(last).
  - Required: 'p'@13 and 'q'@14 written; 'r' dropped.
  - Required: no terminator write, no match_cs; result_err=1, found=0.
- Early zero: base=0; send 'k',0,'m'(last).
  - Required: writes 0:'k', 1:0; 'm' is drained; matcher started; err=0.
- Empty query: first byte 0 with in_last.
  - Required: no writes, no match_cs, result_err=1.
- Reset in WAIT: assert rst while waiting on the matcher.
  - Required: all outputs 0, match_rst=1, state IDLE.
  - Required: a following query loads correctly from its base.
